// File: rtl/clock_reset_sequencer_if.sv
// Status/lock bundle between the DCM-side sequencer and its consumers.
// master: sequencer side; slave: whatever drives lock and observes status.
interface clock_reset_sequencer_if #(
    parameter int LOSS_WIDTH = 8
);
    logic                  locked;
    logic                  sys_rst_n;
    logic                  ready;
    logic                  init_start;
    logic [LOSS_WIDTH-1:0] loss_count;
    logic [1:0]            state_dbg;

    modport master (
        input  locked,
        output sys_rst_n,
        output ready,
        output init_start,
        output loss_count,
        output state_dbg
    );

    modport slave (
        output locked,
        input  sys_rst_n,
        input  ready,
        input  init_start,
        input  loss_count,
        input  state_dbg
    );
endinterface

// File: rtl/clock_reset_sequencer.sv
// Lock synchroniser/filter, SDRAM power-up delay, system reset release and
// lock-loss counting, all on the DCM output clock.
//
// state     | meaning
// ----------+------------------------------------------------------------
// WAIT_LOCK | synchronised lock low; everything held in reset
// FILTER    | lock high, counting LOCK_FILTER stable cycles
// POWERUP   | lock stable, counting POWERUP_CYCLES stabilisation delay
// RUN       | system reset released; lock drops counted
module clock_reset_sequencer #(
    parameter int LOCK_FILTER    = 64,
    parameter int POWERUP_CYCLES = 20000,
    parameter int LOSS_WIDTH     = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    clock_reset_sequencer_if.master bus
);

    localparam int MAX_CNT = (LOCK_FILTER > POWERUP_CYCLES) ? LOCK_FILTER : POWERUP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0]      FILTER_TC  = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0]      POWERUP_TC = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [LOSS_WIDTH-1:0] LOSS_MAX   = '1;

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_FILTER    = 2'd1,
        S_POWERUP   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LOSS_WIDTH-1:0] loss_count_q, loss_count_d;
    logic                  s1_q, s1_d;
    logic                  s2_q, s2_d;
    logic                  sys_rst_n_q, sys_rst_n_d;
    logic                  ready_q, ready_d;
    logic                  init_start_q, init_start_d;
    logic                  lock_s;

    // locked is asynchronous; only the second synchroniser stage is used.
    assign s1_d   = bus.locked;
    assign s2_d   = s1_q;
    assign lock_s = s2_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_WAIT_LOCK;
            cnt_q        <= '0;
            loss_count_q <= '0;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            sys_rst_n_q  <= 1'b0;
            ready_q      <= 1'b0;
            init_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            loss_count_q <= loss_count_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            sys_rst_n_q  <= sys_rst_n_d;
            ready_q      <= ready_d;
            init_start_q <= init_start_d;
        end
    end

    // A lock drop always wins over reaching a terminal count.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        loss_count_d = loss_count_q;
        unique case (state_q)
            S_WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) begin
                    state_d = S_FILTER;
                end
            end
            S_FILTER: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == FILTER_TC) begin
                    state_d = S_POWERUP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_POWERUP: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == POWERUP_TC) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    if (loss_count_q != LOSS_MAX) begin
                        loss_count_d = loss_count_q + LOSS_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = S_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Decoded from the next state so outputs move on the same edge as state.
    always_comb begin
        sys_rst_n_d  = (state_d == S_RUN);
        ready_d      = (state_d == S_RUN);
        init_start_d = (state_d == S_RUN) && (state_q != S_RUN);
    end

    assign bus.sys_rst_n  = sys_rst_n_q;
    assign bus.ready      = ready_q;
    assign bus.init_start = init_start_q;
    assign bus.loss_count = loss_count_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Bench for clock_reset_sequencer: bring-up vector table, hand-written abort,
// loss, saturation and reset sequences, then random lock/reset traffic vs a model.
module tb_clock_reset_sequencer;

    localparam int LF = 4;
    localparam int PC = 10;
    localparam int LW = 2;
    localparam int LOSS_SAT = (1 << LW) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;

    clock_reset_sequencer_if #(.LOSS_WIDTH(LW)) bus ();

    clock_reset_sequencer #(
        .LOCK_FILTER   (LF),
        .POWERUP_CYCLES(PC),
        .LOSS_WIDTH    (LW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int init_seen = 0;

    // Model: the state follows from how many consecutive cycles lock_s has been high.
    logic m_s1, m_s2;
    int   m_run;
    int   m_loss;
    logic m_init;

    function automatic int m_state();
        if (m_run == 0) return 0;
        if (m_run <= LF) return 1;
        if (m_run <= LF + PC) return 2;
        return 3;
    endfunction

    task automatic model_edge(input logic rst, input logic lk);
        int   prev;
        logic ls;
        if (!rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_run = 0; m_loss = 0; m_init = 1'b0;
        end else begin
            prev = m_state();
            ls   = m_s2;
            m_s2 = m_s1;
            m_s1 = lk;
            if (!ls) begin
                if (prev == 3 && m_loss < LOSS_SAT) m_loss++;
                m_run = 0;
            end else if (m_run < LF + PC + 2) begin
                m_run++;
            end
            m_init = (m_run == LF + PC + 1);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic lk);
        int ms;
        @(negedge clock);
        reset      = rst;
        bus.locked = lk;
        @(posedge clock);
        model_edge(rst, lk);
        #1;
        ms = m_state();
        if (bus.init_start) init_seen++;
        check("model_state", int'(bus.state_dbg), ms);
        check("model_sys_rst_n", int'(bus.sys_rst_n), (ms == 3) ? 1 : 0);
        check("model_ready", int'(bus.ready), (ms == 3) ? 1 : 0);
        check("model_init_start", int'(bus.init_start), int'(m_init));
        check("model_loss_count", int'(bus.loss_count), m_loss);
    endtask

    task automatic run_up(output int n);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            step(1'b1, 1'b1);
            n = i;
            if (bus.state_dbg == 2'd3) break;
        end
        check("reach_run", int'(bus.state_dbg), 3);
    endtask

    task automatic drop_lock();
        int fell;
        fell = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0);
            if (!bus.sys_rst_n) fell = 1;
        end
        check("rst_n_low_after_drop", fell, 1);
    endtask

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       rstn;
        logic       init;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen_pu;
        int init_before;
        logic lvl;

        vecs[0] = '{cyc: 1,  st: 2'd0, rstn: 1'b0, init: 1'b0};
        vecs[1] = '{cyc: 2,  st: 2'd1, rstn: 1'b0, init: 1'b0};
        vecs[2] = '{cyc: 5,  st: 2'd1, rstn: 1'b0, init: 1'b0};
        vecs[3] = '{cyc: 6,  st: 2'd2, rstn: 1'b0, init: 1'b0};
        vecs[4] = '{cyc: 15, st: 2'd2, rstn: 1'b0, init: 1'b0};
        vecs[5] = '{cyc: 16, st: 2'd3, rstn: 1'b1, init: 1'b1};
        vecs[6] = '{cyc: 17, st: 2'd3, rstn: 1'b1, init: 1'b0};
        vecs[7] = '{cyc: 18, st: 2'd3, rstn: 1'b1, init: 1'b0};

        bus.locked = 1'b0;
        m_s1 = 1'b0; m_s2 = 1'b0; m_run = 0; m_loss = 0; m_init = 1'b0;

        // Reset state
        repeat (3) step(1'b0, 1'b0);
        check("reset_state", int'(bus.state_dbg), 0);
        check("reset_ready", int'(bus.ready), 0);
        check("reset_loss", int'(bus.loss_count), 0);
        repeat (2) step(1'b1, 1'b0);

        // Bring-up: t = 0 is edge E where locked is first sampled high
        for (int t = 0; t <= 18; t++) begin
            step(1'b1, 1'b1);
            for (int v = 0; v < 8; v++) begin
                if (vecs[v].cyc == t) begin
                    check("bringup_state", int'(bus.state_dbg), int'(vecs[v].st));
                    check("bringup_rst_n", int'(bus.sys_rst_n), int'(vecs[v].rstn));
                    check("bringup_init", int'(bus.init_start), int'(vecs[v].init));
                end
            end
        end

        // Filter abort
        step(1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0);
        seen_pu = 0;
        repeat (3) begin
            step(1'b1, 1'b1);
            if (bus.state_dbg == 2'd2) seen_pu = 1;
        end
        repeat (2) begin
            step(1'b1, 1'b0);
            if (bus.state_dbg == 2'd2) seen_pu = 1;
        end
        n = -1;
        for (int t = 0; t <= 40; t++) begin
            step(1'b1, 1'b1);
            if (bus.state_dbg == 2'd2 && t < 3) seen_pu = 1;
            if (bus.state_dbg == 2'd3) begin
                n = t;
                break;
            end
        end
        check("filter_abort_no_powerup", seen_pu, 0);
        check("filter_abort_run_delay", n, 16);

        // Power-up abort
        step(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1);
            if (bus.state_dbg == 2'd2) break;
        end
        check("pu_entered", int'(bus.state_dbg), 2);
        repeat (4) step(1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        check("pu_abort_state", int'(bus.state_dbg), 0);
        check("pu_abort_ready", int'(bus.ready), 0);
        check("pu_abort_loss", int'(bus.loss_count), 0);

        // Three losses in RUN, one init pulse per entry
        init_before = init_seen;
        for (int i = 0; i < 3; i++) begin
            run_up(n);
            drop_lock();
        end
        check("loss_three", int'(bus.loss_count), 3);
        check("init_per_entry", init_seen - init_before, 3);

        // Saturation from zero
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            run_up(n);
            drop_lock();
            check("sat_loss", int'(bus.loss_count), (i + 1 < LOSS_SAT) ? i + 1 : LOSS_SAT);
        end
        run_up(n);
        check("sat_hold", int'(bus.loss_count), LOSS_SAT);

        // Reset mid-RUN with loss_count = 2
        step(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            run_up(n);
            drop_lock();
        end
        run_up(n);
        check("pre_reset_loss", int'(bus.loss_count), 2);
        step(1'b0, 1'b1);
        check("midrun_reset_state", int'(bus.state_dbg), 0);
        check("midrun_reset_rst_n", int'(bus.sys_rst_n), 0);
        check("midrun_reset_ready", int'(bus.ready), 0);
        check("midrun_reset_init", int'(bus.init_start), 0);
        check("midrun_reset_loss", int'(bus.loss_count), 0);
        run_up(n);
        check("rerun_delay", n, LF + PC + 3);

        // Random lock/reset traffic
        step(1'b0, 1'b0);
        lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (lvl) begin
                if ($urandom_range(0, 59) == 0) lvl = 1'b0;
            end else begin
                if ($urandom_range(0, 2) == 0) lvl = 1'b1;
            end
            step(($urandom_range(0, 499) != 0) ? 1'b1 : 1'b0, lvl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_reset_sequencer.md
Name: clock_reset_sequencer

Overview:
- Sits directly downstream of the DCM clock block. Runs on the DCM's synthesised output clock and consumes its asynchronous lock indication.
- Synchronises and debounces lock, then enforces the SDRAM power-up stabilisation delay.
- Releases an active-low system reset and issues a one-cycle init-start pulse to the SDRAM controller.
- Counts lock-loss events for the test status display.

Parameters:
- LOCK_FILTER, 64: consecutive synchronised lock-high cycles required before the power-up delay starts (≥1).
- POWERUP_CYCLES, 20000: power-up stabilisation delay in clock cycles; 100 µs at 200 MHz (≥1).
- LOSS_WIDTH, 8: width of the lock-loss counter.

Ports:
- clock  in  1  DCM output clock (BUFG-driven); all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- locked  in  1  DCM lock, asynchronous to clock.
- sys_rst_n  out  1  active-low reset to downstream logic; low until RUN.
- ready  out  1  high while in RUN.
- init_start  out  1  one-cycle pulse on the first cycle of RUN.
- loss_count  out  LOSS_WIDTH  number of lock losses seen while in RUN; saturating.
- state_dbg  out  2  current state encoding: 0 WAIT_LOCK, 1 FILTER, 2 POWERUP, 3 RUN.

Behaviour:
- Reset (reset=0 at an edge):
  - state=WAIT_LOCK, sync flops=0, counters=0.
  - sys_rst_n=0, ready=0, init_start=0, loss_count=0.
- Lock synchroniser:
  - Two flops s1←locked, s2←s1; lock_s=s2.
  - Total of 2 cycles latency; no other logic samples locked.
- WAIT_LOCK: cnt←0. If lock_s=1 → FILTER.
- FILTER:
  - If lock_s=0 → WAIT_LOCK, cnt←0.
  - Else if cnt==LOCK_FILTER-1 → POWERUP, cnt←0.
  - Else cnt←cnt+1.
  - FILTER therefore lasts exactly LOCK_FILTER cycles when lock is stable.
- POWERUP:
  - If lock_s=0 → WAIT_LOCK.
  - Else if cnt==POWERUP_CYCLES-1 → RUN.
  - Else cnt←cnt+1.
  - POWERUP lasts exactly POWERUP_CYCLES cycles.
- RUN:
  - If lock_s=0 → WAIT_LOCK, and loss_count←loss_count+1, saturating at all-ones.
  - Otherwise stay in RUN.
- Counter width: a single cnt register of $clog2(max(LOCK_FILTER,POWERUP_CYCLES)+1) bits; comparisons are unsigned.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state:
  - sys_rst_n=1 and ready=1 iff state==RUN.
  - init_start=1 only on the transition edge into RUN; it is 0 in steady RUN.
- End-to-end latency: locked sampled high at edge E with no drops gives FILTER at E+2, POWERUP at E+2+LOCK_FILTER, RUN/ready/init_start at E+2+LOCK_FILTER+POWERUP_CYCLES.
- Lock loss:
  - A lock_s drop in any non-WAIT state aborts to WAIT_LOCK. sys_rst_n and ready go low on that same edge.
  - The full FILTER+POWERUP sequence is repeated on relock.
  - Only drops while in RUN increment loss_count.
- A glitch on locked shorter than one clock may be missed by the synchroniser; this is acceptable.
- reset=0 mid-sequence overrides everything, and loss_count is cleared.
- Simultaneous events:
  - reset has priority over lock_s.
  - In FILTER/POWERUP, lock_s=0 has priority over reaching the terminal count.
- No combinational path from any input to any output.

Test Plan:
- Bring-up (LOCK_FILTER=4, POWERUP_CYCLES=10): release reset, then raise locked and hold it high from edge E.
  - Required: state_dbg=1 at E+2, 2 at E+6, 3 at E+16.
  - init_start=1 only in cycle E+16.
  - sys_rst_n=0 before E+16 and 1 from E+16.
- Filter abort: lock_s high for 3 cycles, then locked low for 2 cycles, then high.
  - Required: return to WAIT_LOCK, no POWERUP entry, and the count restarts.
  - RUN reached 16 cycles after the final rise.
- Power-up abort: drop locked 5 cycles into POWERUP.
  - Required: state=WAIT_LOCK 2 cycles after the drop, ready stays 0, loss_count stays 0.
- Loss in RUN: drop locked 3 times once RUN is reached, with a relock after each drop.
  - Required: loss_count=3, and sys_rst_n low within 3 cycles of each drop.
  - One init_start pulse per re-entry into RUN.
- Saturation (LOSS_WIDTH=2): 5 RUN losses.
  - Required: loss_count=3 and it holds at 3.
- Reset mid-RUN: assert reset=0 for one cycle while in RUN with loss_count=2.
  - Required: all outputs return to their reset values on that edge, and loss_count=0.
  - Full sequence is re-run afterwards with locked still high.
